bram_port_arbiter: RTL and testbench

Shares one BRAM port (the TEMP feature-map buffer) between up to NREQ compute engines of the LeNet-5 accelerator, e.g. conv, pool and FC.
- Grants the port per burst using round-robin.
- Drives the BRAM address/enable/write-enable/data-in signals.
- Routes the BRAM's 1-cycle-latency read data back to the requester that issued each read.
- Sits between the engines and the bram instance, so no engine needs its own port.

---
 rtl/bram_port_arbiter_pkg.sv | 17 +
 rtl/bram_port_arbiter_rr_picker.sv | 29 ++
 rtl/bram_port_arbiter.sv | 133 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and constants for the TEMP-buffer BRAM port arbiter.
package bram_port_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int BRAM_DATA_W = 32;
  localparam int BRAM_BE_W   = 4;

  // Index width that never collapses to zero bits, even for n <= 2.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_picker.sv
// Round-robin picker: first asserted request scanning from ptr upward, modulo NREQ.
module rr_picker #(
  parameter int NREQ  = 3,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int cand;

  // Scan offsets from the far end so the lowest offset from ptr wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[cand[IDX_W-1:0]]) begin
        idx   = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Burst-granular round-robin arbiter sharing one BRAM port among NREQ engines,
// with a tag pipe that steers read data back to the issuing requester.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = BRAM_DATA_W,
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*ADDR_W-1:0]      req_addr,
  input  logic [NREQ*BRAM_BE_W-1:0]   req_we,
  input  logic [NREQ*DATA_W-1:0]      req_wdata,
  input  logic [NREQ-1:0]             req_last,
  output logic [NREQ-1:0]             req_ready,
  output logic [NREQ-1:0]             rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [ADDR_W-1:0]           bram_addr,
  output logic                        bram_en,
  output logic [BRAM_BE_W-1:0]        bram_we,
  output logic [DATA_W-1:0]           bram_din,
  input  logic [DATA_W-1:0]           bram_dout,
  output logic                        bram_rst,
  output logic                        busy
);

  localparam int OWN_W = idx_w(NREQ);
  localparam int CNT_W = idx_w(MAX_BURST);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_t         state;
  logic [OWN_W-1:0]   owner;
  logic [OWN_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   beat_cnt;
  logic [OWN_W-1:0]   pick_idx;
  logic               pick_found;

  logic [ADDR_W-1:0]    addr_a  [NREQ];
  logic [BRAM_BE_W-1:0] we_a    [NREQ];
  logic [DATA_W-1:0]    wdata_a [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_slice
    assign addr_a[k]  = req_addr[k*ADDR_W +: ADDR_W];
    assign we_a[k]    = req_we[k*BRAM_BE_W +: BRAM_BE_W];
    assign wdata_a[k] = req_wdata[k*DATA_W +: DATA_W];
  end

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (OWN_W)
  ) u_rr_picker (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  logic in_grant;
  logic fire;
  logic release_now;

  assign in_grant    = (state == GRANT);
  assign fire        = in_grant && req_valid[owner];
  assign release_now = fire && (req_last[owner] || (beat_cnt == CNT_W'(MAX_BURST - 1)));

  assign busy      = in_grant;
  assign req_ready = in_grant ? (ONE_HOT0 << owner) : '0;
  assign bram_en   = fire;
  assign bram_we   = fire ? we_a[owner] : '0;
  assign bram_addr = in_grant ? addr_a[owner] : '0;
  assign bram_din  = in_grant ? wdata_a[owner] : '0;
  assign bram_rst  = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner <= pick_idx;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            state    <= IDLE;
            beat_cnt <= '0;
            rr_ptr   <= (owner == OWN_W'(NREQ - 1)) ? '0 : owner + 1'b1;
          end else if (fire) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: tag of the beat issued this cycle; writes enter as empty slots.
  logic             vld_p0;
  logic [OWN_W-1:0] own_p0;
  logic             vld_pn [RD_LAT];
  logic [OWN_W-1:0] own_pn [RD_LAT];

  assign vld_p0 = fire && (we_a[owner] == '0);
  assign own_p0 = owner;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) vld_pn[i] <= 1'b0;
    end else begin
      vld_pn[0] <= vld_p0;
      for (int i = 1; i < RD_LAT; i++) vld_pn[i] <= vld_pn[i-1];
    end
  end

  always_ff @(posedge clk) begin
    own_pn[0] <= own_p0;
    for (int i = 1; i < RD_LAT; i++) own_pn[i] <= own_pn[i-1];
  end

  // Stage pN: tag lines up with the BRAM's registered dout.
  assign rsp_valid = vld_pn[RD_LAT-1] ? (ONE_HOT0 << own_pn[RD_LAT-1]) : '0;
  assign rsp_rdata = bram_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a small behavioural BRAM.
module tb_bram_port_arbiter;

  localparam int NREQ = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*4-1:0] req_we;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [31:0]       bram_addr;
  logic              bram_en;
  logic [3:0]        bram_we;
  logic [31:0]       bram_din;
  logic [31:0]       bram_dout;
  logic              bram_rst;
  logic              busy;

  logic [31:0] t_addr  [NREQ];
  logic [3:0]  t_we    [NREQ];
  logic [31:0] t_wdata [NREQ];

  assign req_addr  = {t_addr[2], t_addr[1], t_addr[0]};
  assign req_we    = {t_we[2], t_we[1], t_we[0]};
  assign req_wdata = {t_wdata[2], t_wdata[1], t_wdata[0]};

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .NREQ(NREQ), .ADDR_W(32), .DATA_W(32), .MAX_BURST(16), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .req_last(req_last), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_din(bram_din), .bram_dout(bram_dout), .bram_rst(bram_rst),
    .busy(busy)
  );

  // Behavioural BRAM: 64 words, byte-addressed, 1-cycle read latency.
  logic [31:0] mem [64];
  logic        poke_en;
  logic [5:0]  poke_idx;
  logic [31:0] poke_val;

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end else if (bram_en) begin
      bram_dout <= mem[bram_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr[7:2]][8*b +: 8] <= bram_din[8*b +: 8];
    end
  end

  int nchecks = 0;
  int nerr    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid = '0;
    req_last  = '0;
    for (int k = 0; k < NREQ; k++) begin
      t_addr[k] = '0; t_we[k] = '0; t_wdata[k] = '0;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    drive_idle();
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    tick();
    poke_en = 1'b0;
  endtask

  // Returns in the check phase of the cycle where requester k's beat fires.
  task automatic wait_fire(input int k, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bram_en && req_ready[k]) seen = 1'b1;
      else tick();
    end
    nchecks++;
    if (!seen) begin
      nerr++;
      $display("FAIL %s: no beat from requester %0d within 10 cycles", name, k);
    end
  endtask

  typedef struct {
    logic [2:0]  vld;
    logic [2:0]  last;
    logic [2:0]  exp_rdy;
    logic [2:0]  exp_rsp;
    logic        exp_en;
    logic        exp_busy;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl [11];

  int beats, first_c, last_c, cut_c;
  logic bubble_en;

  initial begin
    poke_en = 1'b0; poke_idx = '0; poke_val = '0;
    rst = 1'b0;
    drive_idle();

    // Reset state while rst is held low
    @(negedge clk);
    check("rst_ctrl", {req_ready, rsp_valid, bram_en, bram_we, busy, bram_rst}, 64'h0);
    check("rst_addr", bram_addr, 64'h0);
    check("rst_din", bram_din, 64'h0);
    tick();
    rst = 1'b1;

    // Single read by requester 1
    poke(6'd4, 32'hDEADBEEF);
    req_valid = 3'b010; t_addr[1] = 32'h10; req_last = 3'b010;
    @(negedge clk);
    check("sr_bubble_en", bram_en, 64'h0);
    check("sr_bubble_busy", busy, 64'h0);
    tick();
    @(negedge clk);
    check("sr_en", bram_en, 64'h1);
    check("sr_addr", bram_addr, 64'h10);
    check("sr_ready", req_ready, 64'h2);
    check("sr_we", bram_we, 64'h0);
    tick();
    drive_idle();
    @(negedge clk);
    check("sr_rsp_valid", rsp_valid, 64'h2);
    check("sr_rsp_data", rsp_rdata, 64'hDEADBEEF);
    check("sr_busy_after", busy, 64'h0);
    tick();

    // Round-robin, 2-beat bursts from all three requesters
    tbl[0]  = '{3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{3'b111, 3'b000, 3'b001, 3'b000, 1'b1, 1'b1, 32'h20};
    tbl[2]  = '{3'b111, 3'b001, 3'b001, 3'b001, 1'b1, 1'b1, 32'h20};
    tbl[3]  = '{3'b111, 3'b000, 3'b000, 3'b001, 1'b0, 1'b0, 32'h0};
    tbl[4]  = '{3'b111, 3'b000, 3'b010, 3'b000, 1'b1, 1'b1, 32'h24};
    tbl[5]  = '{3'b111, 3'b010, 3'b010, 3'b010, 1'b1, 1'b1, 32'h24};
    tbl[6]  = '{3'b111, 3'b000, 3'b000, 3'b010, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{3'b111, 3'b000, 3'b100, 3'b000, 1'b1, 1'b1, 32'h28};
    tbl[8]  = '{3'b111, 3'b100, 3'b100, 3'b100, 1'b1, 1'b1, 32'h28};
    tbl[9]  = '{3'b111, 3'b000, 3'b000, 3'b100, 1'b0, 1'b0, 32'h0};
    tbl[10] = '{3'b111, 3'b000, 3'b001, 3'b000, 1'b1, 1'b1, 32'h20};
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      req_valid = tbl[i].vld;
      req_last  = tbl[i].last;
      t_addr[0] = 32'h20; t_addr[1] = 32'h24; t_addr[2] = 32'h28;
      @(negedge clk);
      check($sformatf("rr%0d_ready", i), req_ready, 64'(tbl[i].exp_rdy));
      check($sformatf("rr%0d_rsp", i), rsp_valid, 64'(tbl[i].exp_rsp));
      check($sformatf("rr%0d_en", i), bram_en, 64'(tbl[i].exp_en));
      check($sformatf("rr%0d_busy", i), busy, 64'(tbl[i].exp_busy));
      if (tbl[i].exp_en) check($sformatf("rr%0d_addr", i), bram_addr, 64'(tbl[i].exp_addr));
      tick();
    end

    // MAX_BURST cut: 20-beat read burst from requester 2
    apply_reset();
    req_valid = 3'b100; t_addr[2] = 32'h60;
    beats = 0; first_c = -1; last_c = -1; cut_c = -10; bubble_en = 1'b1;
    for (int cyc = 0; cyc < 60 && beats < 20; cyc++) begin
      req_last = (beats == 19) ? 3'b100 : 3'b000;
      @(negedge clk);
      if (cyc == cut_c + 1) bubble_en = bram_en;
      if (bram_en) begin
        beats++;
        if (beats == 1) first_c = cyc;
        if (beats == 16) cut_c = cyc;
        if (beats == 20) last_c = cyc;
      end
      tick();
    end
    drive_idle();
    check("mb_beats", 64'(beats), 64'd20);
    check("mb_span", 64'(last_c - first_c + 1), 64'd21);
    check("mb_bubble", bubble_en, 64'h0);
    @(negedge clk);
    check("mb_last_rsp", rsp_valid, 64'h4);
    check("mb_released", busy, 64'h0);
    tick();

    // Write by requester 0, read back by requester 1
    req_valid = 3'b001; t_addr[0] = 32'h40; t_we[0] = 4'hF;
    t_wdata[0] = 32'h12345678; req_last = 3'b001;
    wait_fire(0, "wr_fire");
    check("wr_we", bram_we, 64'hF);
    check("wr_din", bram_din, 64'h12345678);
    tick();
    drive_idle();
    @(negedge clk);
    check("wr_no_rsp", rsp_valid, 64'h0);
    tick();
    req_valid = 3'b010; t_addr[1] = 32'h40; req_last = 3'b010;
    wait_fire(1, "rd_fire");
    tick();
    drive_idle();
    @(negedge clk);
    check("wr_rd_rsp_valid", rsp_valid, 64'h2);
    check("wr_rd_rsp_data", rsp_rdata, 64'h12345678);
    tick();

    // Byte-enable partial write over a zeroed word
    poke(6'h14, 32'h0);
    req_valid = 3'b100; t_addr[2] = 32'h50; t_we[2] = 4'b0011;
    t_wdata[2] = 32'hAABBCCDD; req_last = 3'b100;
    wait_fire(2, "be_wr_fire");
    tick();
    t_we[2] = 4'b0000;
    wait_fire(2, "be_rd_fire");
    tick();
    drive_idle();
    @(negedge clk);
    check("be_rsp_valid", rsp_valid, 64'h4);
    check("be_rsp_data", rsp_rdata, 64'h0000CCDD);
    tick();

    // Reset in the middle of a read burst
    req_valid = 3'b001; t_addr[0] = 32'h40; req_last = 3'b000;
    wait_fire(0, "mr_fire1");
    tick();
    @(negedge clk);
    check("mr_beat2_en", bram_en, 64'h1);
    check("mr_inflight", rsp_valid, 64'h1);
    #1;
    rst = 1'b0;
    drive_idle();
    #1;
    check("mr_async_ctrl", {req_ready, rsp_valid, bram_en, bram_we, busy, bram_rst}, 64'h0);
    check("mr_async_addr", bram_addr, 64'h0);
    check("mr_async_din", bram_din, 64'h0);
    repeat (2) tick();
    rst = 1'b1;
    @(negedge clk);
    check("mr_no_rsp", rsp_valid, 64'h0);
    tick();
    req_valid = 3'b110; req_last = 3'b110;
    @(negedge clk);
    check("mr_bubble_ready", req_ready, 64'h0);
    tick();
    @(negedge clk);
    check("mr_first_grant", req_ready, 64'h2);
    tick();
    drive_idle();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
